mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, giving the number of read beats per burst (2..8).
REQ-002 The block SHALL have parameter WR_RECOVERY, default 1, giving the number of cycles sta1 is held 0 with address/data stable after a write strobe (1..3).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  core access request, sampled only in IDLE.
REQ-006 wr  in  1  1 = write, 0 = read; qualified by req.
REQ-007 burst  in  1  1 = burst read; qualified by req and wr=0.
REQ-008 addr  in  [0:3]  start address.
REQ-009 wdata  in  [0:7]  write data.
REQ-010 busy  out  1  access in progress.
REQ-011 done  out  1  one-cycle pulse at the end of each access.
REQ-012 rvalid  out  1  one-cycle pulse per captured read beat.
REQ-013 rdata  out  [0:7]  last captured read data; holds until the next capture.
REQ-014 address1  out  [0:3]  memory address.
REQ-015 dataout_mp  out  [0:7]  write data to memory.
REQ-016 sta1  out  1  level-sensitive memory write strobe.
REQ-017 datain_mp  in  [0:7]  combinational read data from memory.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, RECOV, BURST.
REQ-019 All outputs SHALL be registered; sta1 SHALL never be 1 in a cycle where address1 or dataout_mp changes.
REQ-020 IDLE, req=1 at edge E0: the block SHALL latch addr, wdata, wr, burst; drive address1=addr and dataout_mp=wdata; set busy=1, sta1=0; and go to SETUP.
REQ-021 Single read: at E1 the block SHALL set rdata=datain_mp and pulse rvalid=1 and done=1, set busy=0, and return to IDLE, giving a 2-edge latency.
REQ-022 Write: at E1 the block SHALL go to STROBE with sta1=1 for exactly one cycle, then go to RECOV with sta1=0 for WR_RECOVERY cycles, then pulse done, set busy=0, and return to IDLE; for WR_RECOVERY=1, done occurs at E3.
REQ-023 Burst read: from E1 onward, each edge SHALL capture datain_mp into rdata, pulse rvalid, and increment address1 modulo 16 (15 wraps to 0), for BURST_LEN beats.
REQ-024 For a burst read, done SHALL coincide with the last rvalid, and busy SHALL fall at the same edge.
REQ-025 req while busy=1 SHALL be ignored (no queuing); the core re-requests after done.
REQ-026 req with wr=1 and burst=1 SHALL perform a single write, with burst ignored.
REQ-027 req held high across done SHALL start a new access at the first IDLE edge, so back-to-back accesses have one IDLE cycle between them.
REQ-028 rdata SHALL be unchanged by writes.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE and set busy=0, done=0, rvalid=0, sta1=0, rdata=0, address1=0, dataout_mp=0.
REQ-030 Reset during STROBE SHALL drop sta1 immediately without waiting for a clock edge.
REQ-031 An aborted access SHALL produce no done pulse.
REQ-032 After rst falls, the first req SHALL be accepted at the next edge.

Configuration
REQ-033 Macro MEM_BUS_BURST_EN: when defined, the BURST state and the burst input behaviour SHALL be compiled in.
REQ-034 When MEM_BUS_BURST_EN is undefined, the BURST state SHALL be absent and burst SHALL be ignored, so every read is a single read per REQ-021.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef and the constants ADDR_W=4, DATA_W=8, MEM_DEPTH=16.
REQ-036 The block SHALL be a single FSM module with no sub-module.
REQ-037 The burst address counter SHALL be the address1 register itself.

Verification (bench pairs the block with the 16x8 main memory after memory reset)
REQ-038 Single read, addr=2 -> rdata=0x4C with rvalid and done at E1; busy high for exactly 1 cycle.
REQ-039 Write 0xA5 to addr=3, then read addr=3 -> sta1 high exactly 1 cycle with address1=3 stable from E0 to E3; read returns 0xA5.
REQ-040 Burst read (MEM_BUS_BURST_EN, BURST_LEN=4), addr=14 -> rdata sequence 0xAC, 0x2D, 0x51, 0x07; address1 sequence 14, 15, 0, 1; done on the 4th rvalid.
REQ-041 req pulsed during an active write -> ignored; exactly one done pulse; memory holds only the first write.
REQ-042 rst asserted mid-cycle while sta1=1 -> sta1=0 before the next edge; no done pulse; outputs match reset values.
REQ-043 Build without MEM_BUS_BURST_EN, burst=1, addr=0 -> single read returning 0x51; one rvalid.

Source files
------------

// File: rtl/mem_bus_master_pkg.sv
// Shared types and constants for the memory bus master.
// Macro MEM_BUS_BURST_EN: when defined, the BURST state exists in the state type.
package mem_bus_master_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 16;

`ifdef MEM_BUS_BURST_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    RECOV  = 3'd3,
    BURST  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    RECOV  = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: bridges a core request/response handshake to a simple
// asynchronous-read memory with a level-sensitive write strobe (sta1).
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req, wr, burst      access request (sampled in IDLE only), direction, burst read
//   addr, wdata         start address, write data
//   busy, done          access in progress, end-of-access pulse
//   rvalid, rdata       read beat pulse, last captured read data
//   address1, dataout_mp, sta1, datain_mp   memory side
//
// Macro MEM_BUS_BURST_EN: compiles in burst reads (BURST state). Without it
// the burst input is ignored and every read is a single read.
//
// All outputs come straight from flops. The write strobe is only raised one
// edge after address/data were loaded and is followed by WR_RECOVERY cycles
// with address/data still held, so sta1 never overlaps an address/data change.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int BURST_LEN   = 4,  // read beats per burst, 2..8
  parameter int WR_RECOVERY = 1   // sta1-low cycles after a strobe, 1..3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic              burst,
  input  logic [0:ADDR_W-1] addr,
  input  logic [0:DATA_W-1] wdata,
  output logic              busy,
  output logic              done,
  output logic              rvalid,
  output logic [0:DATA_W-1] rdata,
  output logic [0:ADDR_W-1] address1,
  output logic [0:DATA_W-1] dataout_mp,
  output logic              sta1,
  input  logic [0:DATA_W-1] datain_mp
);

  state_t            state, state_n;
  logic              wr_q, wr_n;
  logic [1:0]        rec_q, rec_n;
  logic              busy_n, done_n, rvalid_n, sta1_n;
  logic [0:DATA_W-1] rdata_n, dataout_n;
  logic [0:ADDR_W-1] address1_n;

`ifdef MEM_BUS_BURST_EN
  logic              burst_q, burst_n;
  logic [3:0]        beat_q, beat_n;
`else
  logic              unused_burst;
  assign unused_burst = burst;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      rec_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rvalid     <= 1'b0;
      sta1       <= 1'b0;
      rdata      <= '0;
      address1   <= '0;
      dataout_mp <= '0;
`ifdef MEM_BUS_BURST_EN
      burst_q    <= 1'b0;
      beat_q     <= '0;
`endif
    end else begin
      state      <= state_n;
      wr_q       <= wr_n;
      rec_q      <= rec_n;
      busy       <= busy_n;
      done       <= done_n;
      rvalid     <= rvalid_n;
      sta1       <= sta1_n;
      rdata      <= rdata_n;
      address1   <= address1_n;
      dataout_mp <= dataout_n;
`ifdef MEM_BUS_BURST_EN
      burst_q    <= burst_n;
      beat_q     <= beat_n;
`endif
    end
  end

  always_comb begin
    // hold everything; pulses and the strobe default low
    state_n    = state;
    wr_n       = wr_q;
    rec_n      = rec_q;
    busy_n     = busy;
    done_n     = 1'b0;
    rvalid_n   = 1'b0;
    sta1_n     = 1'b0;
    rdata_n    = rdata;
    address1_n = address1;
    dataout_n  = dataout_mp;
`ifdef MEM_BUS_BURST_EN
    burst_n    = burst_q;
    beat_n     = beat_q;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          address1_n = addr;
          dataout_n  = wdata;
          wr_n       = wr;
`ifdef MEM_BUS_BURST_EN
          burst_n    = burst & ~wr;  // a write never bursts
`endif
          busy_n     = 1'b1;
          state_n    = SETUP;
        end
      end
      SETUP: begin
        if (wr_q) begin
          sta1_n  = 1'b1;
          state_n = STROBE;
`ifdef MEM_BUS_BURST_EN
        end else if (burst_q) begin
          // first beat; address1 doubles as the burst address counter
          rdata_n    = datain_mp;
          rvalid_n   = 1'b1;
          address1_n = address1 + ADDR_W'(1);
          beat_n     = 4'd1;
          state_n    = BURST;
`endif
        end else begin
          rdata_n  = datain_mp;
          rvalid_n = 1'b1;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      end
      STROBE: begin
        rec_n   = '0;
        state_n = RECOV;
      end
      RECOV: begin
        if (rec_q == 2'(WR_RECOVERY - 1)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          rec_n = rec_q + 2'd1;
        end
      end
`ifdef MEM_BUS_BURST_EN
      BURST: begin
        rdata_n    = datain_mp;
        rvalid_n   = 1'b1;
        address1_n = address1 + ADDR_W'(1);
        beat_n     = beat_q + 4'd1;
        if (beat_q == 4'(BURST_LEN - 1)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
`endif
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master paired with a 16x8 memory
// (async read, write while sta1 is high). Expected behaviour comes from a
// transaction-level model: per access, a cycle count and the beat values
// from a reference copy of memory.
module tb_mem_bus_master;

  localparam int BL     = 4;
  localparam int WR_REC = 1;
`ifdef MEM_BUS_BURST_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, wr = 1'b0, burst = 1'b0;
  logic [0:3] addr = '0;
  logic [0:7] wdata = '0;
  logic       busy, done, rvalid, sta1;
  logic [0:7] rdata, dataout_mp, datain_mp;
  logic [0:3] address1;

  logic [7:0] mem     [16];  // memory attached to the bus
  logic [7:0] ref_mem [16];  // model's view of memory contents
  logic [7:0] last_rd;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.BURST_LEN(BL), .WR_RECOVERY(WR_REC)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .burst(burst),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rvalid(rvalid), .rdata(rdata), .address1(address1),
    .dataout_mp(dataout_mp), .sta1(sta1), .datain_mp(datain_mp)
  );

  assign datain_mp = mem[address1];
  always @(posedge clk) if (sta1) mem[address1] <= dataout_mp;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:  return 8'h51;
      1:  return 8'h07;
      2:  return 8'h4C;
      14: return 8'hAC;
      15: return 8'h2D;
      default: return 8'(i * 29 + 3);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_chk();
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_rvalid", rvalid, 0);
    chk("idle_sta1", sta1, 0);
  endtask

  // One access from the core's side; called at a negedge. Optionally pulses
  // a second (write) request while the first one is busy.
  task automatic run_txn(input bit w, input bit b, input logic [3:0] a,
                         input logic [7:0] d, input bit intrude);
    int n;
    bit eb;
    logic [3:0] ea;
    logic [7:0] exp;
    eb = b && !w && BEN;
    n  = w ? 2 + WR_REC : (eb ? BL : 1);
    req = 1'b1; wr = w; burst = b; addr = a; wdata = d;
    @(posedge clk); @(negedge clk);
    req = 1'b0; addr = 4'($urandom); wdata = 8'($urandom);
    chk("acc_busy", busy, 1);
    chk("acc_addr", address1, a);
    chk("acc_sta1", sta1, 0);
    chk("acc_done", done, 0);
    if (w) chk("acc_wdata", dataout_mp, d);
    for (int k = 1; k <= n; k++) begin
      if (intrude && k == 1) begin req = 1'b1; wr = 1'b1; addr = a ^ 4'hF; wdata = ~d; end
      if (intrude && k == 2) req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("beat_done", done, (k == n));
      chk("beat_busy", busy, (k < n));
      if (w) begin
        chk("wr_sta1", sta1, (k == 1));
        chk("wr_addr", address1, a);
        chk("wr_data", dataout_mp, d);
        chk("wr_rvalid", rvalid, 0);
        chk("wr_rdata_hold", rdata, last_rd);
      end else begin
        ea  = a + 4'(k - 1);
        exp = ref_mem[ea];
        chk("rd_rvalid", rvalid, 1);
        chk("rd_data", rdata, exp);
        chk("rd_sta1", sta1, 0);
        if (k < n) chk("rd_addr_next", address1, 4'(a + 4'(k)));
        last_rd = exp;
      end
    end
    req = 1'b0;
    if (w) ref_mem[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    last_rd = 8'h00;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_sta1", sta1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", address1, 0);
    chk("rst_dout", dataout_mp, 0);
    rst = 1'b0;

    // single read at 2
    run_txn(1'b0, 1'b0, 4'd2, 8'h00, 1'b0);
    chk("read2_value", rdata, 8'h4C);
    idle_chk();

    // write A5 to 3, read it back
    run_txn(1'b1, 1'b0, 4'd3, 8'hA5, 1'b0);
    idle_chk();
    run_txn(1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
    chk("read3_value", rdata, 8'hA5);
    idle_chk();

    // burst request: 4-beat read when enabled, single read otherwise
`ifdef MEM_BUS_BURST_EN
    run_txn(1'b0, 1'b1, 4'd14, 8'h00, 1'b0);
    chk("burst_last", rdata, 8'h07);
`else
    run_txn(1'b0, 1'b1, 4'd0, 8'h00, 1'b0);
    chk("noburst_value", rdata, 8'h51);
`endif
    idle_chk();

    // write with burst=1 is a plain write
    run_txn(1'b1, 1'b1, 4'd7, 8'h6E, 1'b0);
    idle_chk();

    // request during an active write is dropped
    run_txn(1'b1, 1'b0, 4'd4, 8'h96, 1'b1);
    idle_chk();
    idle_chk();
    run_txn(1'b0, 1'b0, 4'd4 ^ 4'hF, 8'h00, 1'b0);  // untouched location
    idle_chk();

    // back-to-back reads with req held across done
    req = 1'b1; wr = 1'b0; burst = 1'b0; addr = 4'd2;
    @(posedge clk); @(negedge clk);
    chk("b2b_busy0", busy, 1);
    @(posedge clk); @(negedge clk);
    chk("b2b_done0", done, 1);
    chk("b2b_data0", rdata, ref_mem[2]);
    addr = 4'd5;
    @(posedge clk); @(negedge clk);
    chk("b2b_busy1", busy, 1);
    chk("b2b_addr1", address1, 5);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_data1", rdata, ref_mem[5]);
    last_rd = ref_mem[5];
    idle_chk();

    // reset while the strobe is high
    req = 1'b1; wr = 1'b1; burst = 1'b0; addr = 4'd9; wdata = 8'h3C;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_sta1_pre", sta1, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_sta1", sta1, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_addr", address1, 0);
    chk("abort_dout", dataout_mp, 0);
    @(posedge clk); @(negedge clk);
    chk("abort_nodone", done, 0);
    rst = 1'b0;
    last_rd = 8'h00;
    // first request after reset is taken at the next edge
    run_txn(1'b1, 1'b0, 4'd9, 8'h3C, 1'b0);
    idle_chk();

    // randomized accesses
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
      idle_chk();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
